// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: shift-register history with a fill
// count, registered match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int                   SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0]   PATTERN = 4'b1010,
  parameter int                   OVERLAP = 1,
  parameter int                   CNT_W   = 8,
  localparam int                  FILL_W  = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x,
  input  logic              en,
  input  logic              clr,
  output logic              y,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               hit;

  // Next-state candidates for a valid bit; the register block decides
  // whether they are taken (en) or overridden (rst/clr/non-overlap hit).
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    hist_n = {hist[SEQ_LEN-2:0], x};
    fill_n = fill;
    if (fill != FULL) begin
      fill_n = fill + 1'b1;
    end
    // A detection requires a fully populated history, so post-reset zeros
    // never match an all-zero pattern.
    hit = en && (fill_n == FULL) && (hist_n == PATTERN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      y         <= 1'b0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      y         <= 1'b0;
    end else begin
      y <= hit;
      if (en) begin
        hist <= hist_n;
        if (hit && (OVERLAP == 0)) begin
          fill <= '0;
        end else begin
          fill <= fill_n;
        end
        if (hit && (match_cnt != {CNT_W{1'b1}})) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameterisations share one
// stimulus stream and each scenario checks the instances it targets.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;

  logic       y_ov,  y_nov,  y_sat,  y_z;
  logic [7:0] cnt_ov, cnt_nov, cnt_z;
  logic [1:0] cnt_sat;
  logic [2:0] fill_ov, fill_nov, fill_sat;
  logic [1:0] fill_z;

  int checks_total  = 0;
  int checks_passed = 0;
  int pulses;

  always #5 clk = ~clk;

  seq_detect_param u_ov (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y_ov), .match_cnt(cnt_ov), .fill(fill_ov)
  );

  seq_detect_param #(.OVERLAP(0)) u_nov (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y_nov), .match_cnt(cnt_nov), .fill(fill_nov)
  );

  seq_detect_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y_sat), .match_cnt(cnt_sat), .fill(fill_sat)
  );

  seq_detect_param #(.SEQ_LEN(3), .PATTERN(3'b000)) u_z (
    .clk(clk), .rst(rst), .x(x), .en(en), .clr(clr),
    .y(y_z), .match_cnt(cnt_z), .fill(fill_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one bit, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic xi, input logic ei);
    x  = xi;
    en = ei;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    step(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_y",    y_ov,    0);
    check("rst_fill", fill_ov, 0);
    check("rst_cnt",  cnt_ov,  0);
    check("rst_z_y",  y_z,     0);

    // 1,0,1,0,1,0 overlapping vs non-overlapping
    step(1, 1); check("s1_b1_y", y_ov, 0);
    step(0, 1); check("s1_b2_y", y_ov, 0);
    step(1, 1); check("s1_b3_y", y_ov, 0);
    check("s1_b3_fill", fill_ov, 3);
    step(0, 1); check("s1_b4_y_ov", y_ov, 1);
    check("s1_b4_y_nov",    y_nov,    1);
    check("s1_b4_fill_nov", fill_nov, 0);
    check("s1_b4_fill_ov",  fill_ov,  4);
    step(1, 1); check("s1_b5_y_ov", y_ov, 0);
    check("s1_b5_y_nov", y_nov, 0);
    step(0, 1); check("s1_b6_y_ov", y_ov, 1);
    check("s1_b6_y_nov",    y_nov,    0);
    check("s1_cnt_ov",      cnt_ov,   2);
    check("s1_cnt_nov",     cnt_nov,  1);
    check("s1_fill_nov",    fill_nov, 2);
    step(0, 0); check("s1_idle_y", y_ov, 0);
    check("s1_idle_cnt", cnt_ov, 2);

    // en gaps between pattern bits
    do_reset();
    step(1, 1);
    step(0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 0);
      check("s2_gap_y",    y_ov,    0);
      check("s2_gap_fill", fill_ov, 2);
    end
    step(1, 1); check("s2_b3_y", y_ov, 0);
    step(0, 1); check("s2_b4_y", y_ov, 1);
    check("s2_cnt", cnt_ov, 1);
    step(0, 0); check("s2_after_y", y_ov, 0);

    // Reset mid-pattern discards history
    do_reset();
    step(1, 1);
    step(0, 1);
    step(1, 1);
    check("s3_pre_fill", fill_ov, 3);
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    check("s3_rst_fill", fill_ov, 0);
    step(0, 1);
    check("s3_y",    y_ov,    0);
    check("s3_fill", fill_ov, 1);
    check("s3_cnt",  cnt_ov,  0);

    // Counter saturation with CNT_W=2
    do_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(logic'(i % 2 == 0), 1);
      if (y_sat) pulses++;
    end
    check("s4_pulses",  pulses,  5);
    check("s4_cnt_sat", cnt_sat, 3);
    check("s4_cnt_ov",  cnt_ov,  5);

    // All-zero 3-bit pattern right after reset, then clr mid-stream
    do_reset();
    step(0, 1); check("s5_b1_y", y_z, 0);
    check("s5_b1_fill", fill_z, 1);
    step(0, 1); check("s5_b2_y", y_z, 0);
    step(0, 1); check("s5_b3_y", y_z, 1);
    check("s5_b3_fill", fill_z, 3);
    step(0, 1); check("s5_b4_y", y_z, 1);
    check("s5_cnt", cnt_z, 2);
    clr = 1'b1;
    step(0, 1);
    clr = 1'b0;
    check("s5_clr_y",    y_z,    0);
    check("s5_clr_fill", fill_z, 0);
    check("s5_clr_cnt",  cnt_z,  0);
    step(0, 1); check("s5_c1_y", y_z, 0);
    step(0, 1); check("s5_c2_y", y_z, 0);
    check("s5_c2_fill", fill_z, 2);
    step(0, 1); check("s5_c3_y", y_z, 1);
    check("s5_c3_cnt", cnt_z, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter SEQ_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1010, width SEQ_LEN: target sequence; PATTERN[SEQ_LEN-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of match counter.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 x  input  1  serial data bit.
REQ-008 en  input  1  bit-valid qualifier; x sampled only when en=1.
REQ-009 clr  input  1  synchronous soft clear of history, fill and counter.
REQ-010 y  output  1  registered match pulse, one cycle per detection.
REQ-011 match_cnt  output  CNT_W  saturating count of detections.
REQ-012 fill  output  clog2(SEQ_LEN+1)  valid history bits held, 0..SEQ_LEN.

Function
REQ-013 Internal state: hist (SEQ_LEN-bit shift register), fill, match_cnt, y; no other state.
REQ-014 Edge with en=1: hist_n = {hist[SEQ_LEN-2:0], x}; fill_n = min(fill+1, SEQ_LEN).
REQ-015 hit = en && (fill_n == SEQ_LEN) && (hist_n == PATTERN), evaluated at the sampling edge.
REQ-016 y registered from hit: y=1 for exactly the cycle after the edge that sampled the final pattern bit; latency 1 clock.
REQ-017 Edge with en=0: hist, fill, match_cnt hold; y=0.
REQ-018 OVERLAP=1: on hit, fill remains SEQ_LEN; a suffix of the match may start the next match.
REQ-019 OVERLAP=0: on hit, fill loads 0 (hist contents don't-care); next match needs SEQ_LEN fresh bits.
REQ-020 On hit, match_cnt increments by 1; at all-ones it holds (saturates), y still pulses.
REQ-021 No detection while fill < SEQ_LEN, even if hist bits equal PATTERN (e.g. post-reset zeros vs. all-zero pattern).
REQ-022 clr=1 (rst=0): hist=0, fill=0, match_cnt=0, y=0 at that edge; x on that edge discarded regardless of en.
REQ-023 Back-to-back en=1 every cycle supported; y may be high on consecutive cycles (OVERLAP=1 with self-overlapping pattern such as all-ones).
REQ-024 en gaps of any length between pattern bits do not break a match; only valid bits count.

Reset
REQ-025 rst=1 at rising edge: hist=0, fill=0, match_cnt=0, y=0; inputs ignored.
REQ-026 rst has priority over clr and en; reset mid-pattern discards all partial history.
REQ-027 First bit after rst deasserts is sampled at the first rising edge with rst=0 and en=1.

Verification
REQ-028 Defaults, OVERLAP=1, en=1, x=1,0,1,0,1,0 -> y pulses after bits 4 and 6; match_cnt=2.
REQ-029 Same stream, OVERLAP=0 -> y pulses after bit 4 only; match_cnt=1, fill=2 at end.
REQ-030 Defaults, x=1,0 then en=0 for 3 cycles then x=1,0 -> single y pulse one cycle after last bit; y=0 during gap.
REQ-031 Defaults, x=1,0,1 then rst=1 one cycle, then x=0 -> no y; fill=1, match_cnt=0.
REQ-032 CNT_W=2, OVERLAP=1, stream 1,0 repeated 12 bits -> 5 y pulses; match_cnt saturates at 3.
REQ-033 SEQ_LEN=3, PATTERN=3'b000, x=0 immediately after reset -> first y one cycle after third bit, not earlier; clr mid-stream resets fill to 0.
